// File: rtl/sync_ptr_multi.sv
`default_nettype none
// ============================================================================
// Module   : sync_ptr_multi
// Purpose  : Multi-channel Gray pointer synchronizer with binary decode, step
//            delta, change pulse and optional Gray-step checker enabled by
//            the macro SYNC_PTR_GRAY_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module sync_ptr_multi #(
    parameter int ASIZE    = 4,
    parameter int STAGES   = 2,
    parameter int CHANNELS = 1
) (
    input  logic                            wclk,
    input  logic                            wrst,
    input  logic [CHANNELS*(ASIZE+1)-1:0]   ptr_gray,
    output logic [CHANNELS*(ASIZE+1)-1:0]   sync_gray,
    output logic [CHANNELS*(ASIZE+1)-1:0]   sync_bin,
    output logic [CHANNELS*(ASIZE+1)-1:0]   delta,
    output logic [CHANNELS-1:0]             changed,
    input  logic                            err_clr,
    output logic [CHANNELS-1:0]             gray_err
);

    localparam int W = ASIZE + 1;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [W-1:0] r_stage [STAGES];
        logic [W-1:0] w_sync;
        logic [W-1:0] w_bin;
        logic [W-1:0] r_bin;
        logic [W-1:0] r_delta;
        logic         r_changed;

        assign w_sync = r_stage[STAGES-1];

        // Each binary bit is the XOR of all Gray bits at or above it.
        always_comb begin
            w_bin = '0;
            for (int i = 0; i < W; i++) begin
                w_bin[i] = ^(w_sync >> i);
            end
        end

        always_ff @(posedge wclk or posedge wrst) begin
            if (wrst) begin
                for (int s = 0; s < STAGES; s++) begin
                    r_stage[s] <= '0;
                end
                r_bin     <= '0;
                r_delta   <= '0;
                r_changed <= 1'b0;
            end else begin
                r_stage[0] <= ptr_gray[c*W +: W];
                for (int s = 1; s < STAGES; s++) begin
                    r_stage[s] <= r_stage[s-1];
                end
                r_changed <= (w_bin != r_bin);
                // delta keeps its last value while the pointer is idle
                if (w_bin != r_bin) begin
                    r_bin   <= w_bin;
                    r_delta <= w_bin - r_bin;
                end
            end
        end

        assign sync_gray[c*W +: W] = w_sync;
        assign sync_bin[c*W +: W]  = r_bin;
        assign delta[c*W +: W]     = r_delta;
        assign changed[c]          = r_changed;

`ifdef SYNC_PTR_GRAY_CHECK_EN
        logic [W-1:0] r_prev;
        logic         r_armed;
        logic         r_err;
        logic [W-1:0] w_diff;
        logic         w_step;
        logic         w_multi;

        assign w_diff  = w_sync ^ r_prev;
        assign w_step  = |w_diff;
        // More than one bit set: clearing the lowest set bit leaves a remainder.
        assign w_multi = |(w_diff & (w_diff - W'(1)));

        always_ff @(posedge wclk or posedge wrst) begin
            if (wrst) begin
                r_prev  <= '0;
                r_armed <= 1'b0;
                r_err   <= 1'b0;
            end else begin
                r_prev <= w_sync;
                if (w_step) begin
                    r_armed <= 1'b1;
                end
                // A new error outranks a simultaneous clear.
                r_err <= (w_multi & r_armed) | (r_err & ~err_clr);
            end
        end

        assign gray_err[c] = r_err;
`else
        assign gray_err[c] = 1'b0;
`endif
    end : g_ch

`ifndef SYNC_PTR_GRAY_CHECK_EN
    logic w_unused_err_clr;
    assign w_unused_err_clr = err_clr;
`endif

endmodule : sync_ptr_multi
`default_nettype wire

// File: tb/tb_sync_ptr_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_sync_ptr_multi
// Purpose  : Directed self-checking bench for sync_ptr_multi (1- and 4-channel).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sync_ptr_multi;

`ifdef SYNC_PTR_GRAY_CHECK_EN
    localparam logic CHK = 1'b1;
`else
    localparam logic CHK = 1'b0;
`endif

    logic        wclk = 1'b0;
    logic        wrst;
    logic        err_clr;
    logic [4:0]  ptr_gray, sync_gray, sync_bin, delta;
    logic        changed, gray_err;
    logic [19:0] ptr4, sync_gray4, sync_bin4, delta4;
    logic [3:0]  changed4, gray_err4;

    int total = 0;
    int bad   = 0;

    always #5 wclk = ~wclk;

    sync_ptr_multi dut (
        .wclk(wclk), .wrst(wrst), .ptr_gray(ptr_gray), .sync_gray(sync_gray),
        .sync_bin(sync_bin), .delta(delta), .changed(changed),
        .err_clr(err_clr), .gray_err(gray_err)
    );

    sync_ptr_multi #(.ASIZE(4), .STAGES(3), .CHANNELS(4)) dut4 (
        .wclk(wclk), .wrst(wrst), .ptr_gray(ptr4), .sync_gray(sync_gray4),
        .sync_bin(sync_bin4), .delta(delta4), .changed(changed4),
        .err_clr(err_clr), .gray_err(gray_err4)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge wclk);
            @(negedge wclk);
        end
    endtask

    function automatic logic [4:0] gray(input int b);
        logic [4:0] v;
        v = b[4:0];
        return v ^ (v >> 1);
    endfunction

    initial begin
        wrst = 1'b1; err_clr = 1'b0; ptr_gray = '0; ptr4 = '0;
        #1;
        chk("rst_sync_gray", sync_gray, 0);
        chk("rst_sync_bin", sync_bin, 0);
        chk("rst_changed", changed, 0);
        chk("rst_err", gray_err, 0);
        step(2);
        wrst = 1'b0;

        // Latency
        ptr_gray = 5'b00001;
        step(1); chk("lat_sg_e1", sync_gray, 0);
        step(1); chk("lat_sg_e2", sync_gray, 1);
                 chk("lat_bin_e2", sync_bin, 0);
        step(1); chk("lat_bin_e3", sync_bin, 1);
                 chk("lat_chg_e3", changed, 1);
                 chk("lat_dlt_e3", delta, 1);
        step(1); chk("lat_chg_e4", changed, 0);
                 chk("lat_dlt_hold", delta, 1);

        // Walk all Gray codes through the wrap back to 0
        for (int b = 2; b <= 32; b++) begin
            ptr_gray = gray(b % 32);
            step(3);
            chk("wrap_bin", sync_bin, b % 32);
            chk("wrap_dlt", delta, 1);
            chk("wrap_chg", changed, 1);
            step(1);
            chk("wrap_chg_lo", changed, 0);
        end
        chk("wrap_err", gray_err, 0);

        // Illegal two-bit step 00000 -> 00011
        ptr_gray = 5'b00011;
        step(2); chk("err_sg", sync_gray, 5'b00011);
                 chk("err_not_yet", gray_err, 0);
        step(1); chk("err_set", gray_err, CHK);
                 chk("err_bin", sync_bin, 2);
                 chk("err_dlt", delta, 2);
        step(10); chk("err_hold", gray_err, CHK);
        err_clr = 1'b1; step(1); err_clr = 1'b0;
        chk("err_clr1", gray_err, 0);
        ptr_gray = 5'b00101;
        step(2);
        err_clr = 1'b1; step(1); err_clr = 1'b0;
        chk("err_set_wins", gray_err, CHK);
        chk("err2_bin", sync_bin, 6);
        chk("err2_dlt", delta, 4);
        err_clr = 1'b1; step(1); err_clr = 1'b0;
        chk("err_clr2", gray_err, 0);

        // Asynchronous reset with a value in flight
        ptr_gray = gray(7);
        step(1);
        wrst = 1'b1;
        #1;
        chk("arst_sg", sync_gray, 0);
        chk("arst_bin", sync_bin, 0);
        chk("arst_dlt", delta, 0);
        chk("arst_chg", changed, 0);
        step(2);
        wrst = 1'b0;
        step(3); chk("post_bin", sync_bin, 7);
                 chk("post_dlt", delta, 7);
                 chk("post_chg", changed, 1);
        step(1); chk("post_err", gray_err, 0);

        // First change after reset has two flipped bits; check is suppressed
        wrst = 1'b1; #1;
        ptr_gray = gray(2);
        step(1); wrst = 1'b0;
        step(3); chk("sup_bin", sync_bin, 2);
                 chk("sup_chg", changed, 1);
        step(1); chk("sup_err", gray_err, 0);

        // Four channels, only channel 2 moves
        for (int b = 1; b <= 5; b++) begin
            ptr4 = {5'd0, gray(b), 10'd0};
            step(3); chk("mc_chg_early", changed4, 0);
            step(1); chk("mc_chg", changed4, 4'b0100);
                     chk("mc_bin", sync_bin4, 64'(b) << 10);
                     chk("mc_dlt", delta4, 64'd1 << 10);
            step(1); chk("mc_chg_lo", changed4, 0);
        end
        chk("mc_err", gray_err4, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_sync_ptr_multi
`default_nettype wire
